// File: rtl/l1_pkg.sv
// Shared types and defaults for the L1 cacheline request arbiter.
package l1_pkg;

  localparam int unsigned NSTREAMS_DFLT = 8;
  localparam int unsigned MAX_OUT_DFLT  = 16;

  // Width of an index into n items, never narrower than one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned SID_W_DFLT = clog2_min1(NSTREAMS_DFLT);

  typedef logic [SID_W_DFLT-1:0] sid_t;

endpackage

// File: rtl/l1_rr_pick.sv
// Rotating-priority select: first set request after the last grant, wrapping.
module l1_rr_pick
  import l1_pkg::*;
#(
  parameter int unsigned n = NSTREAMS_DFLT,
  parameter int unsigned w = clog2_min1(n)
) (
  input  logic [n-1:0] i_req,
  input  logic [w-1:0] i_last,
  output logic [n-1:0] o_gnt,
  output logic [w-1:0] o_idx,
  output logic         o_any
);

  // Scan last+1 .. last+n modulo n; the first hit wins
  always_comb begin
    int unsigned c;
    logic [w-1:0] ci;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    c     = 0;
    ci    = '0;
    for (int unsigned k = 1; k <= n; k++) begin
      c  = (32'(i_last) + k) % n;
      ci = w'(c);
      if (!o_any && i_req[ci]) begin
        o_any     = 1'b1;
        o_idx     = ci;
        o_gnt[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_clreq_arb.sv
// Round-robin arbiter sharing the L1-to-L2 cacheline request channel among
// stream pointers, with a global in-flight credit cap and response routing.
// Optional statistics outputs are enabled by defining L1_CLREQ_ARB_STATS_EN.
module l1_clreq_arb
  import l1_pkg::*;
#(
  parameter int unsigned nstreams  = NSTREAMS_DFLT,
  parameter int unsigned sid_width = clog2_min1(nstreams),
  parameter int unsigned max_out   = MAX_OUT_DFLT,
  parameter int unsigned cnt_width = $clog2(max_out + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [nstreams-1:0]  i_req_v,
  output logic [nstreams-1:0]  i_req_r,
  output logic                 o_req_v,
  input  logic                 o_req_r,
  output logic [sid_width-1:0] o_req_sid,
  input  logic                 i_rsp_v,
  output logic                 i_rsp_r,
  input  logic [sid_width-1:0] i_rsp_sid,
  output logic [nstreams-1:0]  o_rsp_v,
  output logic [cnt_width-1:0] o_out_cnt,
  output logic                 o_idle,
  output logic                 o_err
`ifdef L1_CLREQ_ARB_STATS_EN
  ,
  output logic [31:0]          o_stall_cnt,
  output logic [cnt_width-1:0] o_hwm
`endif
);

  localparam int unsigned cw1 = cnt_width + 1;

  logic                 r_req_v;
  logic [sid_width-1:0] r_req_sid;
  logic [sid_width-1:0] r_last;
  logic [cnt_width-1:0] r_out_cnt;
  logic                 r_err;

  logic [nstreams-1:0]  w_gnt;
  logic [sid_width-1:0] w_idx;
  logic                 w_any;
  logic                 w_stage_free;
  logic [cw1-1:0]       w_inflight;
  logic                 w_credit_ok;
  logic                 w_accept;
  logic                 w_l2_acc;
  logic                 w_sid_bad;
  logic [cnt_width-1:0] w_cnt_nxt;

  l1_rr_pick #(
    .n (nstreams),
    .w (sid_width)
  ) u_pick (
    .i_req  (i_req_v),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // A staged-but-unsent request already holds a credit
  assign w_stage_free = ~r_req_v | o_req_r;
  assign w_inflight   = cw1'(r_out_cnt) + cw1'(r_req_v);
  assign w_credit_ok  = w_inflight < cw1'(max_out);
  assign w_accept     = w_any & w_stage_free & w_credit_ok;
  assign w_l2_acc     = r_req_v & o_req_r;

  assign i_req_r   = w_accept ? w_gnt : '0;
  assign o_req_v   = r_req_v;
  assign o_req_sid = r_req_sid;
  assign o_out_cnt = r_out_cnt;
  assign o_err     = r_err;
  assign o_idle    = ~r_req_v & (r_out_cnt == '0);
  assign i_rsp_r   = 1'b1;

  // Out-of-range ids are only possible when nstreams is not a power of two
  if (nstreams < (1 << sid_width)) begin : g_sid_chk
    assign w_sid_bad = (32'(i_rsp_sid) >= nstreams);
  end else begin : g_sid_full
    assign w_sid_bad = 1'b0;
  end

  // One-hot response routing; an out-of-range id selects nothing
  always_comb begin
    o_rsp_v = '0;
    for (int unsigned i = 0; i < nstreams; i++) begin
      o_rsp_v[i] = i_rsp_v & (32'(i_rsp_sid) == i);
    end
  end

  // In-flight count: +1 on L2 accept, -1 on response, floor at zero
  always_comb begin
    w_cnt_nxt = r_out_cnt;
    if (w_l2_acc && !i_rsp_v) begin
      w_cnt_nxt = r_out_cnt + cnt_width'(1);
    end else if (!w_l2_acc && i_rsp_v && (r_out_cnt != '0)) begin
      w_cnt_nxt = r_out_cnt - cnt_width'(1);
    end
  end

  // Output stage, grant pointer, counter and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_v   <= 1'b0;
      r_req_sid <= '0;
      r_last    <= sid_width'(nstreams - 1);
      r_out_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_stage_free) begin
        r_req_v <= w_accept;
      end
      if (w_accept) begin
        r_req_sid <= w_idx;
        r_last    <= w_idx;
      end
      r_out_cnt <= w_cnt_nxt;
      if (i_rsp_v && (((r_out_cnt == '0) && !w_l2_acc) || w_sid_bad)) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef L1_CLREQ_ARB_STATS_EN
  logic [31:0]          r_stall_cnt;
  logic [cnt_width-1:0] r_hwm;

  assign o_stall_cnt = r_stall_cnt;
  assign o_hwm       = r_hwm;

  // Credit-stall cycle count (saturating) and in-flight high-water mark
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_hwm       <= '0;
    end else begin
      if ((|i_req_v) && !w_credit_ok && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_cnt_nxt > r_hwm) begin
        r_hwm <= w_cnt_nxt;
      end
    end
  end
`endif

endmodule
